neuron_bus_scheduler: RTL and testbench

Sequencer that owns the `select_external` control of the neuron memory bus multiplexer and shares the bus between the external host port and the internal compute engine. Each requester uses a level request / registered grant handshake. Ownership is round-robin, with a one-cycle turnaround between owners and an optional hold-time limit for fairness. The block also produces a write-inhibit that the bus wrapper ANDs into the muxed `neuron_write_enable`, so no write reaches memory while ownership changes.

---
 rtl/neuron_bus_pkg.sv | 26 ++
 rtl/neuron_bus_scheduler_hold_timer.sv | 28 ++
 rtl/neuron_bus_scheduler.sv | 109 ++++++++++
 tb/tb_neuron_bus_scheduler.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_bus_pkg.sv
// Shared encodings for the neuron memory bus scheduler: FSM states, owner
// identifiers and the hold counter sizing rule.
package neuron_bus_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GNT_INT = 2'd1;
  localparam logic [1:0] ST_GNT_EXT = 2'd2;
  localparam logic [1:0] ST_TURN    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    GNT_INT = ST_GNT_INT,
    GNT_EXT = ST_GNT_EXT,
    TURN    = ST_TURN
  } state_t;

  localparam logic OWNER_INT = 1'b0;
  localparam logic OWNER_EXT = 1'b1;

  // The hold counter must be able to represent MAX_HOLD: 2^HOLD_W > MAX_HOLD.
  function automatic bit hold_w_ok(input int max_hold, input int hold_w);
    return (max_hold >= 0) && (hold_w > 0) && (hold_w < 31) &&
           (max_hold < (1 << hold_w));
  endfunction

endpackage

// File: rtl/neuron_bus_scheduler_hold_timer.sv
// Saturating clear/enable counter that flags when the current owner has been
// contended for MAX_HOLD cycles.
module hold_timer #(
  parameter int MAX_HOLD = 64,
  parameter int HOLD_W   = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic at_limit
);

  logic [HOLD_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && (cnt != '1)) begin
      cnt <= cnt + HOLD_W'(1);
    end
  end

  assign at_limit = (cnt == HOLD_W'(MAX_HOLD));

endmodule

// File: rtl/neuron_bus_scheduler.sv
// Round-robin owner of the neuron memory bus mux select, with a one-cycle
// turnaround between owners and an optional contended hold-time limit.
module neuron_bus_scheduler
  import neuron_bus_pkg::*;
#(
  parameter int MAX_HOLD = 64,
  parameter int HOLD_W   = 7
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ext_req,
  input  logic int_req,
  output logic ext_gnt,
  output logic int_gnt,
  output logic select_external,
  output logic write_inhibit,
  output logic preempted
);

  if (!hold_w_ok(MAX_HOLD, HOLD_W)) begin : g_bad_hold_w
    $error("neuron_bus_scheduler: HOLD_W too narrow for MAX_HOLD");
  end

  state_t state, state_nxt;
  logic   last_owner, last_owner_nxt;
  logic   sel_nxt, ext_gnt_nxt, int_gnt_nxt, preempted_nxt;
  logic   own_req, other_req;
  logic   hold_clr, hold_en, at_limit;

  hold_timer #(
    .MAX_HOLD (MAX_HOLD),
    .HOLD_W   (HOLD_W)
  ) u_hold_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (hold_clr),
    .en       (hold_en),
    .at_limit (at_limit)
  );

  always_comb begin
    state_nxt      = state;
    last_owner_nxt = last_owner;
    preempted_nxt  = 1'b0;
    own_req        = 1'b0;
    other_req      = 1'b0;
    hold_en        = 1'b0;
    case (state)
      IDLE, TURN: begin
        if (ext_req && int_req) begin
          state_nxt = (last_owner == OWNER_EXT) ? GNT_INT : GNT_EXT;
        end else if (ext_req) begin
          state_nxt = GNT_EXT;
        end else if (int_req) begin
          state_nxt = GNT_INT;
        end else begin
          state_nxt = IDLE;
        end
      end
      GNT_INT, GNT_EXT: begin
        own_req   = (state == GNT_EXT) ? ext_req : int_req;
        other_req = (state == GNT_EXT) ? int_req : ext_req;
        hold_en   = other_req;
        // A release wins over a simultaneous timeout, so preempted only
        // fires when the owner still wants the bus.
        if (!own_req || ((MAX_HOLD != 0) && other_req && at_limit)) begin
          state_nxt      = TURN;
          last_owner_nxt = (state == GNT_EXT) ? OWNER_EXT : OWNER_INT;
          preempted_nxt  = own_req;
        end
      end
      default: state_nxt = IDLE;
    endcase

    ext_gnt_nxt = (state_nxt == GNT_EXT);
    int_gnt_nxt = (state_nxt == GNT_INT);
    hold_clr    = ((state == IDLE) || (state == TURN)) && (ext_gnt_nxt || int_gnt_nxt);

    // The select only moves when a new grant is issued; the read path stays
    // pointed at the previous owner through IDLE and TURN.
    sel_nxt = select_external;
    if (ext_gnt_nxt) begin
      sel_nxt = 1'b1;
    end else if (int_gnt_nxt) begin
      sel_nxt = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      last_owner      <= OWNER_EXT;
      ext_gnt         <= 1'b0;
      int_gnt         <= 1'b0;
      select_external <= 1'b0;
      preempted       <= 1'b0;
    end else begin
      state           <= state_nxt;
      last_owner      <= last_owner_nxt;
      ext_gnt         <= ext_gnt_nxt;
      int_gnt         <= int_gnt_nxt;
      select_external <= sel_nxt;
      preempted       <= preempted_nxt;
    end
  end

  assign write_inhibit = ~(ext_gnt | int_gnt);

endmodule

// File: tb/tb_neuron_bus_scheduler.sv
// Directed and randomized bench for neuron_bus_scheduler; two instances
// (MAX_HOLD=4 and MAX_HOLD=0) share the request stimulus.
module tb_neuron_bus_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ext_req, int_req;
  logic [1:0] eg, ig, sx, wi, pr;
  logic [1:0] peg, pig, psx;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state per instance: own 0=none, 1=engine, 2=host.
  int mh[2] = '{4, 0};
  int m_own[2];
  int m_last[2];
  int m_cnt[2];
  bit m_sel[2];
  bit m_pre[2];

  always #5 clk = ~clk;

  neuron_bus_scheduler #(.MAX_HOLD(4), .HOLD_W(7)) u_dut_a (
    .clk             (clk),
    .rst_n           (rst_n),
    .ext_req         (ext_req),
    .int_req         (int_req),
    .ext_gnt         (eg[0]),
    .int_gnt         (ig[0]),
    .select_external (sx[0]),
    .write_inhibit   (wi[0]),
    .preempted       (pr[0])
  );

  neuron_bus_scheduler #(.MAX_HOLD(0), .HOLD_W(7)) u_dut_b (
    .clk             (clk),
    .rst_n           (rst_n),
    .ext_req         (ext_req),
    .int_req         (int_req),
    .ext_gnt         (eg[1]),
    .int_gnt         (ig[1]),
    .select_external (sx[1]),
    .write_inhibit   (wi[1]),
    .preempted       (pr[1])
  );

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_own[k]  = 0;
      m_last[k] = 2;
      m_cnt[k]  = 0;
      m_sel[k]  = 1'b0;
      m_pre[k]  = 1'b0;
    end
    peg = 2'b00;
    pig = 2'b00;
    psx = 2'b00;
  endtask

  task automatic model_step(input int k, input bit e, input bit i);
    bit mine, other;
    m_pre[k] = 1'b0;
    if (m_own[k] != 0) begin
      mine  = (m_own[k] == 2) ? e : i;
      other = (m_own[k] == 2) ? i : e;
      if (!mine) begin
        m_last[k] = m_own[k];
        m_own[k]  = 0;
      end else if (mh[k] != 0 && other && m_cnt[k] == mh[k]) begin
        m_last[k] = m_own[k];
        m_own[k]  = 0;
        m_pre[k]  = 1'b1;
      end else if (other && m_cnt[k] < 127) begin
        m_cnt[k]++;
      end
    end else begin
      if (e && i)  m_own[k] = (m_last[k] == 2) ? 1 : 2;
      else if (e)  m_own[k] = 2;
      else if (i)  m_own[k] = 1;
      if (m_own[k] != 0) begin
        m_cnt[k] = 0;
        m_sel[k] = (m_own[k] == 2);
      end
    end
  endtask

  task automatic cmp_all();
    for (int k = 0; k < 2; k++) begin
      chk($sformatf("ext_gnt[%0d]", k), eg[k], m_own[k] == 2);
      chk($sformatf("int_gnt[%0d]", k), ig[k], m_own[k] == 1);
      chk($sformatf("select_external[%0d]", k), sx[k], m_sel[k]);
      chk($sformatf("write_inhibit[%0d]", k), wi[k], m_own[k] == 0);
      chk($sformatf("preempted[%0d]", k), pr[k], m_pre[k]);
      chk($sformatf("grants_exclusive[%0d]", k), eg[k] & ig[k], 1'b0);
      chk($sformatf("inhibit_is_nor[%0d]", k), wi[k], ~(eg[k] | ig[k]));
      if (sx[k] !== psx[k])
        chk($sformatf("sel_moves_on_grant_rise[%0d]", k),
            (eg[k] & ~peg[k]) | (ig[k] & ~pig[k]), 1'b1);
    end
    peg = eg;
    pig = ig;
    psx = sx;
  endtask

  task automatic cyc(input bit e, input bit i);
    ext_req = e;
    int_req = i;
    @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) model_step(k, e, i);
    cmp_all();
  endtask

  initial begin
    int pre_a, pre_b;
    bit re, ri;

    // Reset values.
    rst_n   = 1'b0;
    ext_req = 1'b0;
    int_req = 1'b0;
    #12;
    model_reset();
    cmp_all();
    chk("reset_write_inhibit", wi[0], 1'b1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Engine request from idle: one-cycle grant latency.
    cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    chk("tp1_int_gnt", ig[0], 1'b1);
    chk("tp1_select", sx[0], 1'b0);
    chk("tp1_inhibit", wi[0], 1'b0);
    cyc(1'b0, 1'b1);

    // Asynchronous reset mid-grant clears grants immediately.
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_int_gnt_a", ig[0], 1'b0);
    chk("async_rst_int_gnt_b", ig[1], 1'b0);
    chk("async_rst_inhibit", wi[0], 1'b1);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cmp_all();

    // Simultaneous requests: engine first, host two cycles after engine drops.
    cyc(1'b1, 1'b1);
    chk("both_int_first", ig[0], 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    chk("turn_no_grant_ext", eg[0], 1'b0);
    chk("turn_no_grant_int", ig[0], 1'b0);
    chk("turn_inhibit", wi[0], 1'b1);
    cyc(1'b1, 1'b0);
    chk("handover_ext_gnt", eg[0], 1'b1);
    chk("handover_select", sx[0], 1'b1);

    // Host holds while engine contends: MAX_HOLD=4 instance times out.
    pre_a = 0;
    for (int n = 0; n < 5; n++) begin
      cyc(1'b1, 1'b1);
      if (pr[0] === 1'b1) pre_a++;
    end
    chk("timeout_ext_dropped", eg[0], 1'b0);
    chk("timeout_preempted", pr[0], 1'b1);
    cyc(1'b1, 1'b1);
    if (pr[0] === 1'b1) pre_a++;
    chk("timeout_int_gnt", ig[0], 1'b1);
    chk("timeout_single_pulse", pre_a == 1, 1'b1);
    chk("unlimited_keeps_ext", eg[1], 1'b1);

    // Engine releases on the very cycle its timeout would hit.
    for (int n = 0; n < 4; n++) cyc(1'b1, 1'b1);
    chk("pre_limit_still_int", ig[0], 1'b1);
    cyc(1'b1, 1'b0);
    chk("release_beats_timeout", pr[0], 1'b0);
    chk("release_turn_int", ig[0], 1'b0);
    cyc(1'b1, 1'b0);
    chk("release_next_ext", eg[0], 1'b1);

    // MAX_HOLD=0 never preempts under sustained contention.
    pre_b = 0;
    for (int n = 0; n < 1000; n++) begin
      cyc(1'b1, 1'b1);
      if (pr[1] === 1'b1) pre_b++;
    end
    chk("unlimited_no_preempt", pre_b == 0, 1'b1);
    chk("unlimited_owner_kept", eg[1], 1'b1);
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    chk("unlimited_handover_int", ig[1], 1'b1);

    // Randomized bursty requests.
    re = 1'b0;
    ri = 1'b0;
    for (int n = 0; n < 10000; n++) begin
      if ($urandom_range(0, 3) == 0) re = ~re;
      if ($urandom_range(0, 3) == 0) ri = ~ri;
      cyc(re, ri);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
